// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for the 5-stage core: EX/MEM/WB destination scoreboard,
// operand forward selects, load-use stall and taken-branch flush. Define HAZARD_STATS_EN for stall/flush counters.
module hazard_fwd_ctrl #(
  parameter int NB_REG_ADDR = 5,
  parameter int NB_FWD_SEL  = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_id_valid,
  input  logic [NB_REG_ADDR-1:0] i_id_rs,
  input  logic [NB_REG_ADDR-1:0] i_id_rt,
  input  logic                   i_id_uses_rt,
  input  logic [NB_REG_ADDR-1:0] i_id_rd,
  input  logic                   i_id_regwrite,
  input  logic                   i_id_memread,
  input  logic                   i_ex_branch_taken,
  output logic [NB_FWD_SEL-1:0]  o_fwd_a_sel,
  output logic [NB_FWD_SEL-1:0]  o_fwd_b_sel,
`ifdef HAZARD_STATS_EN
  output logic [31:0]            o_stall_count,
  output logic [31:0]            o_flush_count,
`endif
  output logic                   o_stall,
  output logic                   o_flush
);

  localparam logic [NB_FWD_SEL-1:0] FWD_RF  = NB_FWD_SEL'(0);
  localparam logic [NB_FWD_SEL-1:0] FWD_WB  = NB_FWD_SEL'(1);
  localparam logic [NB_FWD_SEL-1:0] FWD_MEM = NB_FWD_SEL'(2);

  logic                   ex_valid, ex_regwrite, ex_memread;
  logic [NB_REG_ADDR-1:0] ex_rd;
  logic                   mem_valid, mem_regwrite, mem_memread;
  logic [NB_REG_ADDR-1:0] mem_rd;
  logic                   wb_valid, wb_regwrite, wb_memread;
  logic [NB_REG_ADDR-1:0] wb_rd;

  logic                   ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
  logic                   load_use, id_advance;
  logic [NB_FWD_SEL-1:0]  fwd_a_next, fwd_b_next;
  logic                   unused_wb_state;

  function automatic logic stage_writes(input logic valid, input logic regwrite,
                                        input logic [NB_REG_ADDR-1:0] rd,
                                        input logic [NB_REG_ADDR-1:0] r);
    return valid & regwrite & (rd == r) & (r != '0);
  endfunction

  // Producers in EX now will be in MEM when the ID instruction reaches EX, hence the MEM-result select.
  always_comb begin
    ex_hit_rs  = stage_writes(ex_valid, ex_regwrite, ex_rd, i_id_rs);
    ex_hit_rt  = i_id_uses_rt & stage_writes(ex_valid, ex_regwrite, ex_rd, i_id_rt);
    mem_hit_rs = stage_writes(mem_valid, mem_regwrite, mem_rd, i_id_rs);
    mem_hit_rt = i_id_uses_rt & stage_writes(mem_valid, mem_regwrite, mem_rd, i_id_rt);

    load_use   = i_id_valid & ex_memread & (ex_hit_rs | ex_hit_rt);
    o_flush    = ~i_rst & i_ex_branch_taken;
    o_stall    = ~i_rst & ~i_ex_branch_taken & load_use;
    id_advance = i_id_valid & ~o_stall & ~o_flush;

    fwd_a_next = ex_hit_rs ? FWD_MEM : (mem_hit_rs ? FWD_WB : FWD_RF);
    fwd_b_next = ex_hit_rt ? FWD_MEM : (mem_hit_rt ? FWD_WB : FWD_RF);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ex_valid     <= 1'b0;
      ex_regwrite  <= 1'b0;
      ex_memread   <= 1'b0;
      ex_rd        <= '0;
      mem_valid    <= 1'b0;
      mem_regwrite <= 1'b0;
      mem_memread  <= 1'b0;
      mem_rd       <= '0;
      wb_valid     <= 1'b0;
      wb_regwrite  <= 1'b0;
      wb_memread   <= 1'b0;
      wb_rd        <= '0;
      o_fwd_a_sel  <= FWD_RF;
      o_fwd_b_sel  <= FWD_RF;
    end else begin
      wb_valid     <= mem_valid;
      wb_regwrite  <= mem_regwrite;
      wb_memread   <= mem_memread;
      wb_rd        <= mem_rd;
      mem_valid    <= ex_valid;
      mem_regwrite <= ex_regwrite;
      mem_memread  <= ex_memread;
      mem_rd       <= ex_rd;
      ex_valid     <= id_advance;
      ex_regwrite  <= id_advance & i_id_regwrite;
      ex_memread   <= id_advance & i_id_memread;
      ex_rd        <= id_advance ? i_id_rd : '0;
      o_fwd_a_sel  <= id_advance ? fwd_a_next : FWD_RF;
      o_fwd_b_sel  <= id_advance ? fwd_b_next : FWD_RF;
    end
  end

  // The register file is write-before-read, so the WB slot and the load flag past EX have no consumer here.
  assign unused_wb_state = ^{wb_valid, wb_regwrite, wb_memread, wb_rd, mem_memread};

`ifdef HAZARD_STATS_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_stall_count <= '0;
      o_flush_count <= '0;
    end else begin
      if (o_stall && (o_stall_count != 32'hFFFF_FFFF)) o_stall_count <= o_stall_count + 32'd1;
      if (o_flush && (o_flush_count != 32'hFFFF_FFFF)) o_flush_count <= o_flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
Pipeline hazard and forwarding controller for the 5-stage CPU core. It tracks the destination register of every instruction in EX, MEM and WB through an internal scoreboard. It drives the select codes of the two EX-stage operand 3:1 muxes: 00 = register file, 01 = WB result, 10 = MEM result. It also raises the load-use stall and the taken-branch flush for the IF/ID and ID/EX pipeline registers.

Parameters:
NB_REG_ADDR, 5, width of register specifiers
NB_FWD_SEL, 2, width of each forward select code (fixed to 2; 3:1 operand muxes)

Ports:
i_clk  input  1  system clock, rising edge
i_rst  input  1  reset, synchronous, active-high
i_id_valid  input  1  instruction present in ID
i_id_rs  input  NB_REG_ADDR  source register A of ID instruction
i_id_rt  input  NB_REG_ADDR  source register B of ID instruction
i_id_uses_rt  input  1  ID instruction reads rt as operand
i_id_rd  input  NB_REG_ADDR  destination register of ID instruction
i_id_regwrite  input  1  ID instruction writes register file
i_id_memread  input  1  ID instruction is a load
i_ex_branch_taken  input  1  branch/jump in EX resolved taken this cycle
o_fwd_a_sel  output  NB_FWD_SEL  operand A mux select for instruction currently in EX (registered)
o_fwd_b_sel  output  NB_FWD_SEL  operand B mux select for instruction currently in EX (registered)
o_stall  output  1  hold PC and IF/ID, insert bubble into ID/EX (combinational)
o_flush  output  1  squash IF/ID and ID/EX contents (combinational)

Behaviour:
- Scoreboard: three stage descriptors EX, MEM, WB. Each holds valid, rd, regwrite and memread.
- Every clock: WB <= MEM and MEM <= EX.
  - EX <= ID descriptor if i_id_valid & !o_stall & !o_flush; otherwise EX <= bubble (valid=0).
- A descriptor "writes r" when: valid & regwrite & rd == r & r != 0.
- Forward select, computed from the ID operands and registered on the same edge that loads EX:
  - Value 10 if the current EX descriptor writes the operand; else 01 if the current MEM descriptor writes it; else 00.
  - MEM-stage match (10) has priority over WB-stage match (01).
  - Operand B is evaluated only when i_id_uses_rt=1; otherwise its select is 00.
  - Register 0 is never forwarded.
  - The register file is write-before-read, so a WB-stage producer needs no forwarding for the instruction in ID.
- When EX loads a bubble, o_fwd_a_sel and o_fwd_b_sel load 00.
- Load-use stall:
  - o_stall=1 when i_id_valid & EX.valid & EX.memread & EX writes (i_id_rs, or i_id_rt with i_id_uses_rt).
  - Lasts exactly one cycle. The next cycle the load is in MEM and the dependent instruction is re-evaluated, yielding select 01.
- Flush:
  - o_flush = i_ex_branch_taken.
  - Flush overrides stall: o_stall is forced to 0 when o_flush=1.
  - The ID instruction is discarded and EX receives a bubble.
  - Back-to-back taken branches flush each cycle.
- Reset (i_rst=1 at a rising edge):
  - All descriptors become invalid; o_fwd_a_sel and o_fwd_b_sel = 00.
  - o_stall and o_flush are forced to 0 while i_rst=1, including mid-stall.
  - The first cycle after reset produces no hazards.
- Latency:
  - Stall and flush are same-cycle combinational.
  - Forward selects are valid in the cycle the consumer occupies EX.

Optional Feature:
HAZARD_STATS_EN
- Defined:
  - Adds ports o_stall_count (32, output) and o_flush_count (32, output).
  - Each counter increments on every cycle its signal is 1, saturates at 32'hFFFF_FFFF, and is cleared by i_rst.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
1. add r3 <- r1,r2 then sub r4 <- r3,r5 back-to-back -> sub in EX with o_fwd_a_sel=10, o_fwd_b_sel=00, no stall.
2. add r3 <- ..., nop, or r6 <- r7,r3 -> or in EX with o_fwd_b_sel=01, o_fwd_a_sel=00.
3. lw r8 <- 0(r1) then add r9 <- r8,r8 -> o_stall=1 for exactly one cycle, then add in EX with both selects 01.
4. add r0 <- r1,r2 then sub r4 <- r0,r0 -> both selects 00 (r0 never forwarded).
5. lw r8 followed by a dependent add, with i_ex_branch_taken=1 in the same cycle -> o_flush=1, o_stall=0, EX bubble, selects 00 next cycle.
6. Assert i_rst for 1 cycle while o_stall=1 -> o_stall=0 during reset; selects 00 and no stall the following cycle. With HAZARD_STATS_EN, o_stall_count=0 after reset.
